// File: rtl/term_ctrl.sv
// Text terminal controller: turns a byte stream into VRAM writes,
// with cursor tracking, line feed, hardware scroll and clear screen.
module term_ctrl #(
    parameter int LINES = 17,
    parameter int COLS  = 60
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_char,
    input  logic        i_char_valid,
    output logic        o_char_ready,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_din,
    input  logic [7:0]  i_vram_dout,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic [4:0]  o_cursor_row,
    output logic [5:0]  o_cursor_col,
    output logic        o_busy
);

    localparam logic [4:0] LAST_ROW = 5'(LINES - 1);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [7:0] SPACE    = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SCR_RD,
        SCR_WR,
        SCR_CLR,
        CLS
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [7:0]  char_q, char_d;
    logic [4:0]  scn_row_q, scn_row_d;
    logic [5:0]  scn_col_q, scn_col_d;

    logic        is_cr;
    logic        is_lf;
    logic        is_bs;
    logic        is_ff;
    logic        is_prn;
    logic [4:0]  dst_row;

    // Byte classification of the incoming character.
    always_comb begin
        is_cr  = (i_char == 8'h0D);
        is_lf  = (i_char == 8'h0A);
        is_bs  = (i_char == 8'h08);
        is_ff  = (i_char == 8'h0C);
        is_prn = (i_char >= 8'h20) && (i_char != 8'h7F);
    end

    // Scroll copies each source row into the row just above it.
    always_comb begin
        dst_row = scn_row_q - 5'd1;
    end

    // State register, cursor and scan counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            row_q     <= 5'd0;
            col_q     <= 6'd0;
            char_q    <= 8'h00;
            scn_row_q <= 5'd0;
            scn_col_q <= 6'd0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            char_q    <= char_d;
            scn_row_q <= scn_row_d;
            scn_col_q <= scn_col_d;
        end
    end

    // Next-state, cursor update and VRAM port drive.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        char_d       = char_q;
        scn_row_d    = scn_row_q;
        scn_col_d    = scn_col_q;
        o_char_ready = 1'b0;
        o_vram_ce    = 1'b1;
        o_vram_wre   = 1'b1;
        o_vram_addr  = {row_q, col_q};
        o_vram_din   = 8'h00;

        unique case (state_q)
            IDLE: begin
                o_char_ready = 1'b1;
                o_vram_ce    = 1'b0;
                o_vram_wre   = 1'b0;
                if (i_char_valid) begin
                    unique case (1'b1)
                        is_cr: begin
                            col_d = 6'd0;
                        end
                        is_lf: begin
                            if (row_q != LAST_ROW) begin
                                row_d = row_q + 5'd1;
                            end else begin
                                state_d   = SCR_RD;
                                scn_row_d = 5'd1;
                                scn_col_d = 6'd0;
                            end
                        end
                        is_bs: begin
                            if (col_q != 6'd0) begin
                                col_d = col_q - 6'd1;
                            end
                        end
                        is_ff: begin
                            state_d   = CLS;
                            scn_row_d = 5'd0;
                            scn_col_d = 6'd0;
                        end
                        is_prn: begin
                            char_d  = i_char;
                            state_d = WRITE;
                        end
                        default: begin
                        end
                    endcase
                end
            end

            WRITE: begin
                o_vram_din = char_q;
                state_d    = IDLE;
                if (col_q != LAST_COL) begin
                    col_d = col_q + 6'd1;
                end else begin
                    col_d = 6'd0;
                    if (row_q != LAST_ROW) begin
                        row_d = row_q + 5'd1;
                    end else begin
                        state_d   = SCR_RD;
                        scn_row_d = 5'd1;
                        scn_col_d = 6'd0;
                    end
                end
            end

            SCR_RD: begin
                o_vram_wre  = 1'b0;
                o_vram_addr = {scn_row_q, scn_col_q};
                state_d     = SCR_WR;
            end

            SCR_WR: begin
                o_vram_addr = {dst_row, scn_col_q};
                o_vram_din  = i_vram_dout;
                state_d     = SCR_RD;
                if (scn_col_q != LAST_COL) begin
                    scn_col_d = scn_col_q + 6'd1;
                end else begin
                    scn_col_d = 6'd0;
                    if (scn_row_q != LAST_ROW) begin
                        scn_row_d = scn_row_q + 5'd1;
                    end else begin
                        state_d = SCR_CLR;
                    end
                end
            end

            SCR_CLR: begin
                o_vram_addr = {LAST_ROW, scn_col_q};
                o_vram_din  = SPACE;
                if (scn_col_q != LAST_COL) begin
                    scn_col_d = scn_col_q + 6'd1;
                end else begin
                    scn_col_d = 6'd0;
                    state_d   = IDLE;
                end
            end

            CLS: begin
                o_vram_addr = {scn_row_q, scn_col_q};
                o_vram_din  = SPACE;
                if (scn_col_q != LAST_COL) begin
                    scn_col_d = scn_col_q + 6'd1;
                end else begin
                    scn_col_d = 6'd0;
                    if (scn_row_q != LAST_ROW) begin
                        scn_row_d = scn_row_q + 5'd1;
                    end else begin
                        scn_row_d = 5'd0;
                        row_d     = 5'd0;
                        col_d     = 6'd0;
                        state_d   = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Cursor and busy outputs.
    always_comb begin
        o_cursor_row = row_q;
        o_cursor_col = col_q;
        o_busy       = ~o_char_ready;
    end

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: VRAM model, screen-level reference model,
// directed scenarios followed by a random byte stream.
`timescale 1ns/1ps
module tb_term_ctrl;

    localparam int LINES = 17;
    localparam int COLS  = 60;
    localparam int SCROLL_LAT = (LINES - 1) * COLS * 2 + COLS;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_char = 8'h00;
    logic        i_char_valid = 1'b0;
    logic        o_char_ready;
    logic [10:0] o_vram_addr;
    logic [7:0]  o_vram_din;
    logic [7:0]  i_vram_dout;
    logic        o_vram_ce;
    logic        o_vram_wre;
    logic [4:0]  o_cursor_row;
    logic [5:0]  o_cursor_col;
    logic        o_busy;

    term_ctrl #(.LINES(LINES), .COLS(COLS)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_char       (i_char),
        .i_char_valid (i_char_valid),
        .o_char_ready (o_char_ready),
        .o_vram_addr  (o_vram_addr),
        .o_vram_din   (o_vram_din),
        .i_vram_dout  (i_vram_dout),
        .o_vram_ce    (o_vram_ce),
        .o_vram_wre   (o_vram_wre),
        .o_cursor_row (o_cursor_row),
        .o_cursor_col (o_cursor_col),
        .o_busy       (o_busy)
    );

    always #21 i_clk = ~i_clk;

    // VRAM model with a bench-side preload port.
    logic [7:0]  vram [0:2047];
    logic        pl_en = 1'b0;
    logic [10:0] pl_addr = 11'd0;
    logic [7:0]  pl_data = 8'h00;
    int          wr_cnt = 0;
    int          acc_cnt = 0;
    int          bad_addr = 0;
    int          busy_bad = 0;
    logic [10:0] last_waddr = 11'd0;
    logic [7:0]  last_wdata = 8'h00;

    always @(posedge i_clk) begin
        if (pl_en) begin
            vram[pl_addr] <= pl_data;
        end else if (o_vram_ce && o_vram_wre) begin
            vram[o_vram_addr] <= o_vram_din;
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= o_vram_addr;
            last_wdata <= o_vram_din;
        end
        if (o_vram_ce && !o_vram_wre) i_vram_dout <= vram[o_vram_addr];
        if (o_vram_ce) acc_cnt <= acc_cnt + 1;
        if (o_vram_ce && (int'(o_vram_addr[10:6]) >= LINES ||
                          int'(o_vram_addr[5:0]) >= COLS))
            bad_addr <= bad_addr + 1;
        if (o_busy !== ~o_char_ready) busy_bad <= busy_bad + 1;
    end

    // Reference model: screen contents and cursor.
    logic [7:0] scr [LINES][COLS];
    int m_row = 0;
    int m_col = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_lf(inout int lat);
        if (m_row < LINES - 1) begin
            m_row++;
        end else begin
            for (int r = 0; r < LINES - 1; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < COLS; c++) scr[LINES-1][c] = 8'h20;
            lat += SCROLL_LAT;
        end
    endtask

    task automatic m_apply(input logic [7:0] b, output int lat);
        lat = 0;
        if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_lf(lat);
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            for (int r = 0; r < LINES; r++)
                for (int c = 0; c < COLS; c++) scr[r][c] = 8'h20;
            m_row = 0;
            m_col = 0;
            lat = LINES * COLS;
        end else if (b >= 8'h20 && b != 8'h7F) begin
            scr[m_row][m_col] = b;
            lat = 1;
            if (m_col < COLS - 1) begin
                m_col++;
            end else begin
                m_col = 0;
                m_lf(lat);
            end
        end
    endtask

    // Hand one byte over and count the cycles ready stays low.
    task automatic send(input logic [7:0] b, output int low);
        @(negedge i_clk);
        chk("ready_before_send", 32'(o_char_ready), 32'd1);
        i_char = b;
        i_char_valid = 1'b1;
        @(posedge i_clk);
        #1 i_char_valid = 1'b0;
        low = 0;
        @(negedge i_clk);
        while (o_char_ready !== 1'b1 && low < 5000) begin
            low++;
            @(negedge i_clk);
        end
    endtask

    task automatic send_chk(input logic [7:0] b, input string tag);
        int lat;
        int low;
        m_apply(b, lat);
        send(b, low);
        chk({tag, "_lowcycles"}, 32'(low), 32'(lat));
        chk({tag, "_cursor"}, {21'd0, o_cursor_row, o_cursor_col},
            {21'd0, 5'(m_row), 6'(m_col)});
    endtask

    task automatic cmp_screen(input string tag);
        int bad = 0;
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < COLS; c++)
                if (vram[r*64 + c] !== scr[r][c]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int w0;
        int a0;
        int low;
        int u;
        logic [7:0] b;

        // Reset values.
        repeat (3) @(negedge i_clk);
        chk("rst_ready", 32'(o_char_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_ce_wre", {30'd0, o_vram_ce, o_vram_wre}, 32'd0);
        chk("rst_din", 32'(o_vram_din), 32'd0);
        chk("rst_addr", 32'(o_vram_addr), 32'd0);
        chk("rst_cursor", {21'd0, o_cursor_row, o_cursor_col}, 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("idle_ce", 32'(o_vram_ce), 32'd0);

        // Clear screen.
        w0 = wr_cnt;
        send_chk(8'h0C, "cls");
        chk("cls_writes", 32'(wr_cnt - w0), 32'(LINES * COLS));
        chk("cls_last_addr", 32'(last_waddr), {21'd0, 5'(LINES-1), 6'(COLS-1)});
        cmp_screen("cls_screen");

        // Single printable byte.
        w0 = wr_cnt;
        send_chk(8'h41, "A");
        chk("A_writes", 32'(wr_cnt - w0), 32'd1);
        chk("A_addr", 32'(last_waddr), 32'd0);
        chk("A_data", 32'(last_wdata), 32'h41);

        // Full row of 0x42 from column 0.
        send_chk(8'h0D, "cr0");
        for (int i = 0; i < COLS; i++) send_chk(8'h42, "row0");
        chk("row_last_addr", 32'(last_waddr), {21'd0, 5'd0, 6'(COLS-1)});
        cmp_screen("row_screen");

        // CR / BS at {3,30}: no VRAM access, ready never drops.
        send_chk(8'h0A, "lf1");
        send_chk(8'h0A, "lf2");
        for (int i = 0; i < 30; i++) send_chk(8'h61, "to_col30");
        a0 = acc_cnt;
        send_chk(8'h0D, "cr");
        send_chk(8'h08, "bs1");
        send_chk(8'h08, "bs2");
        chk("crbs_cursor", {21'd0, o_cursor_row, o_cursor_col},
            {21'd0, 5'd3, 6'd0});
        chk("crbs_no_access", 32'(acc_cnt - a0), 32'd0);

        // Scroll from {16,5} with row r preloaded to value r.
        for (int i = 0; i < 13; i++) send_chk(8'h0A, "to_row16");
        for (int i = 0; i < 5; i++) send_chk(8'h62, "to_col5");
        for (int r = 0; r < LINES; r++)
            for (int c = 0; c < COLS; c++) begin
                @(negedge i_clk);
                pl_en = 1'b1;
                pl_addr = {5'(r), 6'(c)};
                pl_data = 8'(r);
                scr[r][c] = 8'(r);
            end
        @(negedge i_clk);
        pl_en = 1'b0;
        send_chk(8'h0A, "scroll");
        cmp_screen("scroll_screen");

        // Random byte stream against the model.
        for (int n = 0; n < 120; n++) begin
            u = $urandom_range(0, 99);
            if (u < 30) b = 8'($urandom_range(8'h20, 8'h7E));
            else if (u < 50) b = 8'($urandom_range(8'h80, 8'hFF));
            else if (u < 64) b = 8'h0A;
            else if (u < 74) b = 8'h0D;
            else if (u < 84) b = 8'h08;
            else if (u < 87) b = 8'h0C;
            else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h08 || b == 8'h0A || b == 8'h0C || b == 8'h0D)
                    b = 8'h7F;
            end
            send_chk(b, "rand");
            if (n % 40 == 39) cmp_screen("rand_screen");
        end
        chk("addr_range", 32'(bad_addr), 32'd0);
        chk("busy_inverse", 32'(busy_bad), 32'd0);

        // Reset in the middle of a scroll.
        while (m_row < LINES - 1) send_chk(8'h0A, "to_bottom");
        @(negedge i_clk);
        i_char = 8'h0A;
        i_char_valid = 1'b1;
        @(posedge i_clk);
        #1 i_char_valid = 1'b0;
        repeat (100) @(negedge i_clk);
        chk("midscroll_busy", 32'(o_char_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("abort_ce", 32'(o_vram_ce), 32'd0);
        chk("abort_cursor", {21'd0, o_cursor_row, o_cursor_col}, 32'd0);
        chk("abort_ready", 32'(o_char_ready), 32'd1);
        a0 = acc_cnt;
        repeat (3) @(negedge i_clk);
        chk("abort_no_access", 32'(acc_cnt - a0), 32'd0);
        i_rst_n = 1'b1;
        m_row = 0;
        m_col = 0;
        send(8'h41, low);
        chk("post_rst_low", 32'(low), 32'd1);
        chk("post_rst_addr", 32'(last_waddr), 32'd0);
        chk("post_rst_data", 32'(last_wdata), 32'h41);
        chk("post_rst_cursor", {21'd0, o_cursor_row, o_cursor_col},
            {21'd0, 5'd0, 6'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
